// File: rtl/mac_loader.sv
// Streams pixel and weight words into a MAC tap memory, then sequences the MAC's
// compute strobe and result-valid pulse for each completed window.
module mac_loader #(
    parameter int unsigned DW   = 16,
    parameter int unsigned TAPS = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_w,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          mem_we,
    output logic [4:0]    mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          mem_en,
    output logic          out_valid,
    output logic [15:0]   win_count
);

    localparam logic [2:0] StPix   = 3'd0;
    localparam logic [2:0] StWgt   = 3'd1;
    localparam logic [2:0] StDrain = 3'd2;
    localparam logic [2:0] StFire  = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    localparam logic [3:0] LastTap  = 4'(TAPS - 1);
    localparam logic [4:0] WgtBase  = 5'(TAPS);

    logic [2:0] state_q;
    logic [3:0] cnt_q;
    logic       wgt_ok_q;
    logic       accept;
    logic       last_tap;
    logic       load_req;

    // A kernel reload may only begin on a window boundary.
    assign load_req = (state_q == StPix) && start_w && (cnt_q == 4'd0);
    assign last_tap = (cnt_q == LastTap);
    assign accept   = in_valid && in_ready;

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            StWgt:   in_ready = 1'b1;
            StPix:   in_ready = wgt_ok_q && !(start_w && (cnt_q == 4'd0));
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StPix;
            cnt_q     <= 4'd0;
            wgt_ok_q  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 5'd0;
            mem_data  <= '0;
            mem_en    <= 1'b0;
            out_valid <= 1'b0;
            win_count <= 16'd0;
        end else begin
            mem_we    <= accept;
            mem_en    <= 1'b0;
            out_valid <= 1'b0;
            if (accept) begin
                mem_data <= in_data;
                mem_addr <= (state_q == StWgt) ? (WgtBase + {1'b0, cnt_q}) : {1'b0, cnt_q};
            end

            case (state_q)
                StPix: begin
                    if (load_req) begin
                        state_q <= StWgt;
                        cnt_q   <= 4'd0;
                    end else if (accept) begin
                        if (last_tap) begin
                            cnt_q   <= 4'd0;
                            state_q <= StDrain;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                StWgt: begin
                    if (accept) begin
                        if (last_tap) begin
                            cnt_q    <= 4'd0;
                            wgt_ok_q <= 1'b1;
                            state_q  <= StPix;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                // Lets the last tap write land before the MAC reads the memory.
                StDrain: begin
                    state_q <= StFire;
                    mem_en  <= 1'b1;
                end
                StFire: begin
                    state_q   <= StDone;
                    out_valid <= 1'b1;
                    win_count <= win_count + 16'd1;
                end
                StDone:  state_q <= StPix;
                default: state_q <= StPix;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_loader.sv
// Self-checking bench for mac_loader: transaction-level model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_mac_loader;

    localparam int DW   = 16;
    localparam int TAPS = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_w = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          mem_we;
    logic [4:0]    mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_en;
    logic          out_valid;
    logic [15:0]   win_count;

    mac_loader #(.DW(DW), .TAPS(TAPS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_w   (start_w),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_en    (mem_en),
        .out_valid (out_valid),
        .win_count (win_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d (0x%0h), want %0d (0x%0h)",
                     nm, $time, $signed(act), act, $signed(exp), exp);
        end
    endtask

    // Model: a window is TAPS accepted pixels, then a 3-cycle tail (drain, fire, done).
    bit   chk_en = 0;
    bit   m_load, m_wok;
    int   m_cnt, m_tail, m_wins;
    bit   pw_v;
    int   pw_a;
    logic [DW-1:0] pw_d;
    bit   exp_rdy, acc;
    logic signed [DW-1:0] mtap [32];
    logic signed [DW-1:0] dtap [32];
    int   dut_mac, mod_mac;
    int   we_cnt = 0;
    int   en_cnt = 0;

    always @(negedge clk) begin
        exp_rdy = (m_tail == 0) && (m_load || (m_wok && !(start_w && m_cnt == 0)));
        if (chk_en) begin
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("mem_we", 32'(mem_we), 32'(pw_v));
            if (pw_v) begin
                chk("mem_addr", 32'(mem_addr), 32'(pw_a));
                chk("mem_data", 32'(mem_data), 32'(pw_d));
            end
            chk("mem_en", 32'(mem_en), 32'(m_tail == 2));
            chk("out_valid", 32'(out_valid), 32'(m_tail == 3));
            chk("win_count", 32'(win_count), 32'(m_wins));
            if (mem_we) begin
                dtap[mem_addr] = mem_data;
                we_cnt++;
            end
            if (mem_en) begin
                en_cnt++;
                dut_mac = 0;
                for (int i = 0; i < TAPS; i++) dut_mac += int'(dtap[i]) * int'(dtap[TAPS + i]);
            end
            if (out_valid) begin
                mod_mac = 0;
                for (int i = 0; i < TAPS; i++) mod_mac += int'(mtap[i]) * int'(mtap[TAPS + i]);
                chk("mac_result", 32'(dut_mac), 32'(mod_mac));
            end
        end
        // Advance the model with the inputs the next rising edge will see.
        if (rst) begin
            m_load = 0; m_wok = 0; m_cnt = 0; m_tail = 0; m_wins = 0; pw_v = 0;
            chk_en = 1;
        end else if (chk_en) begin
            acc  = in_valid && exp_rdy;
            pw_v = acc;
            if (acc) begin
                pw_a = m_load ? TAPS + m_cnt : m_cnt;
                pw_d = in_data;
                mtap[pw_a] = in_data;
            end
            if (m_tail != 0) begin
                if (m_tail == 2) m_wins = (m_wins + 1) % 65536;
                m_tail = (m_tail == 3) ? 0 : m_tail + 1;
            end else if (!m_load && start_w && m_cnt == 0) begin
                m_load = 1;
            end else if (acc) begin
                if (m_cnt == TAPS - 1) begin
                    m_cnt = 0;
                    if (m_load) begin
                        m_load = 0;
                        m_wok  = 1;
                    end else begin
                        m_tail = 1;
                    end
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    logic [DW-1:0] wts_a [TAPS] = '{16'd2, 16'd3, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    logic [DW-1:0] pix_a [TAPS] = '{16'd1, 16'd2, 16'hFFFD, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds one word on the input until it is accepted.
    task automatic send(input logic [DW-1:0] d, input logic sw);
        bit ok;
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        start_w  = sw;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 50);
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        start_w  = 1'b0;
    endtask

    task automatic pulse_start();
        start_w = 1'b1;
        idle(1);
        start_w = 1'b0;
    endtask

    task automatic wait_ov();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 10);
        if (!out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle(2);
        rst = 1'b0;

        // Without a kernel, pixels are refused.
        in_valid = 1'b1;
        in_data  = 16'd5;
        idle(20);
        in_valid = 1'b0;
        chk("no_write_without_kernel", 32'(we_cnt), 32'd0);

        // Kernel load.
        pulse_start();
        for (int i = 0; i < TAPS; i++) send(wts_a[i], 1'b0);
        idle(2);
        chk("w_addr9", 32'(dtap[9]), 32'd2);
        chk("w_addr10", 32'(dtap[10]), 32'd3);
        chk("w_addr11", 32'(dtap[11]), 32'd4);
        chk("no_en_on_load", 32'(en_cnt), 32'd0);
        chk("ready_after_load", 32'(in_ready), 32'd1);

        // Back-to-back window.
        for (int i = 0; i < TAPS; i++) send(pix_a[i], 1'b0);
        wait_ov();
        chk("mac_lit_w1", 32'(dut_mac), 32'hFFFF_FFFC);
        chk("win_count_w1", 32'(win_count), 32'd1);

        // Same window with gaps.
        for (int i = 0; i < TAPS; i++) begin
            send(pix_a[i], 1'b0);
            idle(1);
        end
        wait_ov();
        chk("mac_lit_w2", 32'(dut_mac), 32'hFFFF_FFFC);
        chk("en_once_w2", 32'(en_cnt), 32'd2);

        // start_w with in_valid at window boundary: no acceptance, reload begins.
        start_w  = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'd7;
        idle(1);
        start_w  = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < TAPS; i++) send(16'd1, 1'b0);
        // start_w mid-window is ignored.
        for (int i = 0; i < TAPS; i++) send(16'(i + 1), i == 4);
        wait_ov();
        chk("mac_lit_w3", 32'(dut_mac), 32'd45);
        chk("win_count_w3", 32'(win_count), 32'd3);

        // Reset mid-window abandons it and drops the kernel.
        for (int i = 0; i < 5; i++) send(pix_a[i], 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i);
            idle(1);
        end
        in_valid = 1'b0;
        chk("win_count_after_rst", 32'(win_count), 32'd0);
        chk("no_en_after_rst", 32'(en_cnt), 32'd3);
        pulse_start();
        for (int i = 0; i < TAPS; i++) send(wts_a[i], 1'b0);
        for (int i = 0; i < TAPS; i++) send(pix_a[i], 1'b0);
        wait_ov();
        chk("mac_lit_w4", 32'(dut_mac), 32'hFFFF_FFFC);
        chk("win_count_w4", 32'(win_count), 32'd1);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
